fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC sequencing, one-deep memory pipeline, FIFO to decode
module fetch_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  output logic                          imem_req,
  output logic [ADDR_WIDTH-1:0]         imem_addr,
  input  logic [DATA_WIDTH-1:0]         imem_rdata,
  input  logic                          redirect_valid,
  input  logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_WIDTH-1:0]         out_pc,
  output logic [DATA_WIDTH-1:0]         out_instruction,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Occupancy is count + inflight, which can reach QUEUE_DEPTH + 1 bits worth
  // of headroom, so compare in a one-bit-wider domain.
  localparam logic [CNT_W:0] DEPTH_EXT = (CNT_W + 1)'(QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  // Fetch PC and the single outstanding memory request.
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;

  // Queue storage and bookkeeping.
  logic [ADDR_WIDTH-1:0] pc_mem    [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic [CNT_W:0]        occupancy;
  logic                  issue;
  logic                  push;
  logic                  pop;

  // Credit check counts the outstanding request as already occupying a slot,
  // and ignores a same-cycle pop so the decision never depends on out_ready.
  always_comb begin
    occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    issue     = reset_n && !redirect_valid && (occupancy < DEPTH_EXT);
    out_valid = reset_n && (count != '0);
    push      = reset_n && inflight && !redirect_valid;
    pop       = out_valid && out_ready;
  end

  assign imem_req        = issue;
  assign imem_addr       = pc;
  assign queue_count     = count;
  assign out_pc          = pc_mem[rd_ptr];
  assign out_instruction = instr_mem[rd_ptr];

  // Queue payload write; contents are only meaningful where count says so,
  // so the storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= inflight_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

  // PC sequencing, request tracking and queue pointers; redirect flushes
  // everything after any coinciding pop has been handed to the consumer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ALIGN_MASK;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + PC_STEP;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit
module tb_fetch_unit;

  localparam int QD = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic [2:0]  queue_count;

  logic        reset_n_s;
  logic        imem_req_s;
  logic [7:0]  imem_addr_s;
  logic [31:0] imem_rdata_s;
  logic        out_valid_s;
  logic [7:0]  out_pc_s;
  logic [31:0] out_instruction_s;
  logic [2:0]  queue_count_s;

  fetch_unit dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instruction(out_instruction),
    .queue_count(queue_count)
  );

  fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(8'hF8)) dut_small (
    .clk(clk), .reset_n(reset_n_s),
    .imem_req(imem_req_s), .imem_addr(imem_addr_s), .imem_rdata(imem_rdata_s),
    .redirect_valid(1'b0), .redirect_pc(8'h00),
    .out_valid(out_valid_s), .out_ready(1'b1),
    .out_pc(out_pc_s), .out_instruction(out_instruction_s),
    .queue_count(queue_count_s)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program memory: answers one cycle after a request, junk otherwise.
  always @(posedge clk) begin
    imem_rdata   <= imem_req   ? mem_word(imem_addr)   : $urandom();
    imem_rdata_s <= imem_req_s ? {24'h0, imem_addr_s}  : $urandom();
  end

  // Reference model: an abstract queue of fetched PCs plus one pending request.
  logic [31:0] m_q[$];
  bit          m_inflight = 1'b0;
  logic [31:0] m_inflight_pc = 32'h0;
  logic [31:0] m_pc = 32'h0;

  // Monitor: compare DUT against the model, then advance the model.
  always @(negedge clk) begin : monitor
    int sz;
    bit exp_req;
    bit exp_valid;
    sz        = m_q.size();
    exp_req   = reset_n && !redirect_valid && ((sz + int'(m_inflight)) < QD);
    exp_valid = reset_n && (sz != 0);
    check("imem_req", 64'(imem_req), 64'(exp_req));
    if (exp_req) check("imem_addr", 64'(imem_addr), 64'(m_pc));
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    check("queue_count", 64'(queue_count), 64'(sz));
    if (exp_valid) begin
      check("out_pc", 64'(out_pc), 64'(m_q[0]));
      check("out_instruction", 64'(out_instruction), 64'(mem_word(m_q[0])));
    end
    if (!reset_n) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_pc       = 32'h0;
    end else begin
      if (exp_valid && out_ready) void'(m_q.pop_front());
      if (redirect_valid) begin
        m_q.delete();
        m_inflight = 1'b0;
        m_pc       = {redirect_pc[31:2], 2'b00};
      end else begin
        if (m_inflight) m_q.push_back(m_inflight_pc);
        m_inflight = exp_req;
        if (exp_req) begin
          m_inflight_pc = m_pc;
          m_pc          = m_pc + 32'd4;
        end
      end
    end
  end

  // Narrow-address instance: delivered PCs must wrap through the top of memory.
  logic [7:0] exp_s [4] = '{8'hF8, 8'hFC, 8'h00, 8'h04};
  int s_idx = 0;
  always @(negedge clk) begin
    if (reset_n_s && out_valid_s && s_idx < 4) begin
      check("small_out_pc", 64'(out_pc_s), 64'(exp_s[s_idx]));
      check("small_out_instruction", 64'(out_instruction_s), 64'({24'h0, exp_s[s_idx]}));
      s_idx++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int bias;
    reset_n        = 1'b0;
    reset_n_s      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    step(3);
    reset_n   = 1'b1;
    reset_n_s = 1'b1;
    // Streaming from reset with the consumer always ready.
    step(12);
    // Backpressure until full, then drain.
    out_ready = 1'b0;
    step(12);
    out_ready = 1'b1;
    step(10);
    // Redirect with two queued and one in flight.
    reset_n = 1'b0;
    step(1);
    reset_n   = 1'b1;
    out_ready = 1'b0;
    step(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step(1);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    step(8);
    // Misaligned redirect target.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    step(1);
    redirect_valid = 1'b0;
    step(6);
    // Single-cycle reset with three entries queued.
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step(1);
    redirect_valid = 1'b0;
    step(4);
    reset_n = 1'b0;
    step(1);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    step(10);
    // Randomized traffic with varying consumer throughput.
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 64) == 0) bias = int'($urandom_range(0, 100));
      reset_n        = ($urandom_range(0, 99) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom();
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      out_ready      = (int'($urandom_range(0, 99)) < bias);
      step(1);
    end
    reset_n        = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    step(6);
    check("small_delivered", 64'(s_idx), 64'(4));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
